// File: rtl/rvfi_gen_pkg.sv
// Shared types for the RVFI retirement generator: the buffered commit record
// and the PC-advance rule applied to every retiring lane.
package rvfi_gen_pkg;

  localparam int unsigned MAX_XLEN = 64;

  typedef struct packed {
    logic [31:0]         insn;
    logic                redirect;
    logic [MAX_XLEN-1:0] target;
    logic                trap;
  } rvfi_rec_t;

  // Computed at full width; callers truncate to XLEN, which gives the wrap.
  function automatic logic [MAX_XLEN-1:0] next_pc(
    input rvfi_rec_t           rec,
    input logic [MAX_XLEN-1:0] pre_pc,
    input logic [MAX_XLEN-1:0] trap_vec
  );
    if (rec.trap)                 return trap_vec;
    if (rec.redirect)             return rec.target;
    if (rec.insn[1:0] != 2'b11)   return pre_pc + 64'd2;
    return pre_pc + 64'd4;
  endfunction

endpackage

// File: rtl/rvfi_gen_fifo.sv
// Circular record buffer: one push per cycle, 0..NRET pops per cycle, with the
// NRET oldest entries visible at once so all lanes can be formed together.
module rvfi_gen_fifo
  import rvfi_gen_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned NRET  = 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push_i,
  input  rvfi_rec_t                push_rec_i,
  input  logic [$clog2(DEPTH):0]   pop_cnt_i,
  output rvfi_rec_t                head_o [NRET],
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  rvfi_rec_t       mem_q [DEPTH];
  logic [AW-1:0]   rd_ptr_q;
  logic [AW-1:0]   wr_ptr_q;
  logic [CW-1:0]   count_q;

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_rec_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(push_i);
      rd_ptr_q <= rd_ptr_q + AW'(pop_cnt_i);
      count_q  <= count_q + CW'(push_i) - pop_cnt_i;
    end
  end

  // Multi-lane pop needs several simultaneous reads, so this stays a register file.
  for (genvar gi = 0; gi < NRET; gi++) begin : g_head
    assign head_o[gi] = mem_q[rd_ptr_q + AW'(gi)];
  end

  assign count_o = count_q;

endmodule

// File: rtl/rvfi_retire_gen.sv
// RVFI producer: buffers commit records and retires up to NRET per cycle,
// chaining pre/post PC across lanes and numbering retirements with rvfi_order.
module rvfi_retire_gen
  import rvfi_gen_pkg::*;
#(
  parameter int unsigned    XLEN     = 32,
  parameter int unsigned    NRET     = 1,
  parameter int unsigned    DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC = 'h10
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_insn,
  input  logic                   in_redirect,
  input  logic [XLEN-1:0]        in_target,
  input  logic                   in_trap,
  input  logic                   retire_stall,
  output logic [NRET-1:0]        rvfi_valid,
  output logic [NRET*8-1:0]      rvfi_order,
  output logic [NRET*32-1:0]     rvfi_insn,
  output logic [NRET*5-1:0]      rvfi_rs1,
  output logic [NRET*5-1:0]      rvfi_rs2,
  output logic [NRET*5-1:0]      rvfi_rd,
  output logic [NRET*XLEN-1:0]   rvfi_pre_pc,
  output logic [NRET*XLEN-1:0]   rvfi_post_pc,
  output logic [NRET-1:0]        rvfi_post_trap,
  output logic [NRET*XLEN-1:0]   rvfi_pre_rs1,
  output logic [NRET*XLEN-1:0]   rvfi_pre_rs2,
  output logic [NRET*XLEN-1:0]   rvfi_post_rd,
  output logic [NRET*XLEN-1:0]   rvfi_mem_addr,
  output logic [NRET*XLEN-1:0]   rvfi_mem_rdata,
  output logic [NRET*XLEN-1:0]   rvfi_mem_wdata,
  output logic [NRET*XLEN/8-1:0] rvfi_mem_rmask,
  output logic [NRET*XLEN/8-1:0] rvfi_mem_wmask
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  rvfi_rec_t       head [NRET];
  rvfi_rec_t       push_rec;
  logic [CW-1:0]   count;
  logic [CW-1:0]   pop_cnt;
  logic            push;
  logic            in_ready_q;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [7:0]      order_q, order_d;
  logic [XLEN-1:0] lane_pre  [NRET];
  logic [XLEN-1:0] lane_post [NRET];

  assign push     = in_valid && in_ready_q;
  assign push_rec = '{insn: in_insn, redirect: in_redirect,
                      target: MAX_XLEN'(in_target), trap: in_trap};

  rvfi_gen_fifo #(
    .DEPTH (DEPTH),
    .NRET  (NRET)
  ) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push_i     (push),
    .push_rec_i (push_rec),
    .pop_cnt_i  (pop_cnt),
    .head_o     (head),
    .count_o    (count)
  );

  assign pop_cnt = retire_stall ? '0 : ((count > CW'(NRET)) ? CW'(NRET) : count);

  // Each lane starts where the previous one ended; pc_d follows the last popped lane.
  always_comb begin : p_chain
    logic [XLEN-1:0] pc_run;
    pc_run  = pc_q;
    pc_d    = pc_q;
    order_d = order_q + 8'(pop_cnt);
    for (int k = 0; k < NRET; k++) begin
      lane_pre[k]  = pc_run;
      lane_post[k] = XLEN'(next_pc(head[k], MAX_XLEN'(pc_run), MAX_XLEN'(TRAP_VEC)));
      pc_run       = lane_post[k];
      if (CW'(k) < pop_cnt) begin
        pc_d = lane_post[k];
      end
    end
  end

  // in_ready looks ahead at next occupancy so it is purely registered.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_q       <= RESET_PC;
      order_q    <= '0;
      in_ready_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      order_q    <= order_d;
      in_ready_q <= (count + CW'(push) - pop_cnt) != CW'(DEPTH);
    end
  end

  assign in_ready = in_ready_q;

  for (genvar gi = 0; gi < NRET; gi++) begin : g_lane
    logic            fire;
    logic            comp;
    logic            valid_q;
    logic [7:0]      ord_q;
    logic [31:0]     insn_q;
    logic [4:0]      rs1_q, rs2_q, rd_q;
    logic [XLEN-1:0] pre_q, post_q;
    logic            trap_q;

    assign fire = CW'(gi) < pop_cnt;
    assign comp = head[gi].insn[1:0] != 2'b11;

    always_ff @(posedge clk) begin
      if (!resetn || !fire) begin
        valid_q <= 1'b0;
        ord_q   <= '0;
        insn_q  <= '0;
        rs1_q   <= '0;
        rs2_q   <= '0;
        rd_q    <= '0;
        pre_q   <= '0;
        post_q  <= '0;
        trap_q  <= 1'b0;
      end else begin
        valid_q <= 1'b1;
        ord_q   <= order_q + 8'(gi);
        insn_q  <= head[gi].insn;
        rs1_q   <= comp ? 5'd0 : head[gi].insn[19:15];
        rs2_q   <= comp ? 5'd0 : head[gi].insn[24:20];
        rd_q    <= comp ? 5'd0 : head[gi].insn[11:7];
        pre_q   <= lane_pre[gi];
        post_q  <= lane_post[gi];
        trap_q  <= head[gi].trap;
      end
    end

    assign rvfi_valid[gi]                  = valid_q;
    assign rvfi_order[gi*8 +: 8]           = ord_q;
    assign rvfi_insn[gi*32 +: 32]          = insn_q;
    assign rvfi_rs1[gi*5 +: 5]             = rs1_q;
    assign rvfi_rs2[gi*5 +: 5]             = rs2_q;
    assign rvfi_rd[gi*5 +: 5]              = rd_q;
    assign rvfi_pre_pc[gi*XLEN +: XLEN]    = pre_q;
    assign rvfi_post_pc[gi*XLEN +: XLEN]   = post_q;
    assign rvfi_post_trap[gi]              = trap_q;
  end

  assign rvfi_pre_rs1   = '0;
  assign rvfi_pre_rs2   = '0;
  assign rvfi_post_rd   = '0;
  assign rvfi_mem_addr  = '0;
  assign rvfi_mem_rdata = '0;
  assign rvfi_mem_wdata = '0;
  assign rvfi_mem_rmask = '0;
  assign rvfi_mem_wmask = '0;

endmodule
